// File: rtl/board_print_pkg.sv
// Shared types and constants for the board print path (controller, formatter, benches).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package board_print_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE,
    START,
    WARM,
    STEP,
    SAMPLE,
    SEND
  } print_state_t;

  // Characters in one nominal board frame produced by the formatter
  localparam int FRAME_CHARS = 580;

  // ASCII codes the formatter emits for frame structure
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_BAR  = 8'h7C;

endpackage

// File: rtl/board_print_ctrl.sv
// Sequences the board formatter (start, warm-up, per-char step) and forwards each char to the UART.
// Latency: 2 + WARMUP + 3/char + 2 cycles request-to-frame_done with tx_ready held high.
// Backpressure: tx_valid/tx_data held in SEND until tx_ready; each stalled cycle adds one cycle.
module board_print_ctrl
  import board_print_pkg::*;
#(
  parameter int WARMUP    = 104,
  parameter int MAX_CHARS = 640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       print_req,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout,
  output logic [9:0] chars_sent,
  output logic       str_start,
  output logic       str_print_nxt,
  input  logic [7:0] str_char,
  input  logic       str_done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int               WCW       = $clog2(WARMUP);
  localparam logic [WCW-1:0]   WARM_LOAD = WCW'(WARMUP - 1);
  localparam logic [9:0]       CHARS_LIM = 10'(MAX_CHARS);
  localparam logic [9:0]       CHARS_SAT = 10'h3FF;

  print_state_t   state_q, state_d;
  logic [WCW-1:0] warm_q, warm_d;
  logic [9:0]     chars_q, chars_d;
  logic           pending_q, pending_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           str_start_q, str_start_d;
  logic           str_print_nxt_q, str_print_nxt_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_data_q, tx_data_d;

  // State and registered outputs; reset drops any frame in flight immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      warm_q          <= '0;
      chars_q         <= '0;
      pending_q       <= 1'b0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      str_start_q     <= 1'b0;
      str_print_nxt_q <= 1'b0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= 8'h00;
    end else begin
      state_q         <= state_d;
      warm_q          <= warm_d;
      chars_q         <= chars_d;
      pending_q       <= pending_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      str_start_q     <= str_start_d;
      str_print_nxt_q <= str_print_nxt_d;
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
    end
  end

  // Next state; strobes are computed one cycle early so they are high during START/STEP
  always_comb begin
    state_d         = state_q;
    warm_d          = warm_q;
    chars_d         = chars_q;
    pending_d       = pending_q;
    err_d           = err_q;
    busy_d          = busy_q;
    frame_done_d    = 1'b0;
    str_start_d     = 1'b0;
    str_print_nxt_d = 1'b0;
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;

    // Requests during a frame collapse into a single re-print
    if (state_q != IDLE && print_req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (print_req || pending_q) begin
          pending_d   = 1'b0;
          chars_d     = '0;
          busy_d      = 1'b1;
          str_start_d = 1'b1;
          state_d     = START;
        end else begin
          busy_d = 1'b0;
        end
      end
      START: begin
        warm_d  = WARM_LOAD;
        state_d = WARM;
      end
      WARM: begin
        if (warm_q == '0) begin
          str_print_nxt_d = 1'b1;
          state_d         = STEP;
        end else begin
          warm_d = warm_q - WCW'(1);
        end
      end
      STEP: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (str_done) begin
          frame_done_d = 1'b1;
          busy_d       = pending_q || print_req;
          state_d      = IDLE;
        end else if (chars_q == CHARS_LIM) begin
          err_d   = 1'b1;
          busy_d  = pending_q || print_req;
          state_d = IDLE;
        end else begin
          tx_data_d  = str_char;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d      = 1'b0;
          str_print_nxt_d = 1'b1;
          state_d         = STEP;
          if (chars_q != CHARS_SAT) begin
            chars_d = chars_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign err_timeout   = err_q;
  assign chars_sent    = chars_q;
  assign str_start     = str_start_q;
  assign str_print_nxt = str_print_nxt_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;

endmodule
